// File: rtl/ifu.sv
// Instruction fetch unit: issues sequential fetches, buffers in-order
// responses, hands instruction words to decode and flushes on redirects.
module ifu #(
  parameter int              XLEN       = 64,
  parameter int              INST_WIDTH = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 64'h8000_0000,
  parameter int              DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [XLEN-1:0]       imem_req_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [INST_WIDTH-1:0] imem_rsp_data_i,
  input  logic                  imem_rsp_err_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [XLEN-1:0]       inst_pc_o,
  output logic                  inst_fault_o,
  input  logic                  redirect_i,
  input  logic [XLEN-1:0]       redirect_pc_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 2;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] fetch_pc, fetch_pc_next;
  logic [XLEN-1:0] rsp_pc, rsp_pc_next;
  logic [CW-1:0]   live, live_next;
  logic [CW-1:0]   drop, drop_next;
  logic [CW-1:0]   count;

  logic [INST_WIDTH-1:0] mem_inst  [DEPTH];
  logic [XLEN-1:0]       mem_pc    [DEPTH];
  logic                  mem_fault [DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;

  logic                  req_fire;
  logic                  pop;
  logic                  push;
  logic [INST_WIDTH-1:0] push_inst;
  logic                  push_fault;
  logic                  flush;
  logic                  inject_fault;
  logic [SW-1:0]         credits_used;

  // Request side: every outstanding or buffered word consumes one credit
  always_comb begin
    credits_used     = SW'(live) + SW'(drop) + SW'(count);
    imem_req_valid_o = (state == RUN) && !redirect_i && (credits_used < SW'(DEPTH));
    imem_req_addr_o  = fetch_pc;
    req_fire         = imem_req_valid_o && imem_req_ready_i;
  end

  // Head of the buffer drives decode directly
  always_comb begin
    inst_valid_o = (count != '0);
    inst_o       = mem_inst[rd_ptr];
    inst_pc_o    = mem_pc[rd_ptr];
    inst_fault_o = mem_fault[rd_ptr];
    pop          = inst_valid_o && inst_ready_i;
  end

  // Next-state logic: redirect overrides everything, then responses and requests
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    rsp_pc_next   = rsp_pc;
    live_next     = live;
    drop_next     = drop;
    push          = 1'b0;
    push_inst     = imem_rsp_data_i;
    push_fault    = 1'b0;
    flush         = 1'b0;
    inject_fault  = 1'b0;
    if (redirect_i) begin
      flush         = 1'b1;
      fetch_pc_next = redirect_pc_i;
      rsp_pc_next   = redirect_pc_i;
      live_next     = '0;
      drop_next     = drop + live - CW'(imem_rsp_valid_i);
      if (redirect_pc_i[1:0] != 2'b00) begin
        inject_fault = 1'b1;
        state_next   = HALT;
      end else begin
        state_next   = RUN;
      end
    end else begin
      if (state == BOOT) begin
        state_next = RUN;
      end
      if (req_fire) begin
        fetch_pc_next = fetch_pc + XLEN'(4);
        live_next     = live + CW'(1);
      end
      if (imem_rsp_valid_i) begin
        if (drop != '0) begin
          drop_next = drop - CW'(1);
        end else begin
          push        = 1'b1;
          rsp_pc_next = rsp_pc + XLEN'(4);
          live_next   = live + CW'(req_fire) - CW'(1);
          if (imem_rsp_err_i) begin
            push_inst  = '0;
            push_fault = 1'b1;
            state_next = HALT;
            drop_next  = live + CW'(req_fire) - CW'(1);
            live_next  = '0;
          end
        end
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      live     <= '0;
      drop     <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      rsp_pc   <= rsp_pc_next;
      live     <= live_next;
      drop     <= drop_next;
    end
  end

  // Instruction buffer; a misaligned redirect leaves exactly one fault entry
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i]  <= '0;
        mem_pc[i]    <= '0;
        mem_fault[i] <= 1'b0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      if (inject_fault) begin
        mem_inst[0]  <= '0;
        mem_pc[0]    <= redirect_pc_i;
        mem_fault[0] <= 1'b1;
        wr_ptr       <= PW'(1);
        count        <= CW'(1);
      end else begin
        wr_ptr <= '0;
        count  <= '0;
      end
    end else begin
      if (push) begin
        mem_inst[wr_ptr]  <= push_inst;
        mem_pc[wr_ptr]    <= rsp_pc;
        mem_fault[wr_ptr] <= push_fault;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule
